// File: rtl/up_down_cnt_pkg.sv
// Shared types and helpers for the parametrised up/down counter.
//   cnt_mode_e : mode decode of {cnt_in1, cnt_in0}
//   clog2_min1 : register width needed to hold 0..n-1, never below 1 bit
package up_down_cnt_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_UP   = 2'b01,
    CNT_DOWN = 2'b10,
    CNT_LOAD = 2'b11
  } cnt_mode_e;

  // Bits needed to represent values 0..n-1; a 1-bit minimum keeps vectors legal.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/cnt_tick_gen.sv
// Prescaler: emits one tick every PRESCALE cycles in which run is high.
// Ports:
//   cnt_clk  in   clock
//   cnt_rst  in   async active-low reset
//   run      in   advance the prescaler this cycle
//   clr      in   synchronous clear of the prescaler
//   tick     out  high in the run cycle that completes a prescale period
// With PRESCALE == 1 no register exists and tick follows run directly.
module cnt_tick_gen
  import up_down_cnt_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic cnt_clk,
  input  logic cnt_rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  if (PRESCALE <= 1) begin : g_direct
    logic w_unused;
    assign w_unused = ^{cnt_clk, cnt_rst, clr};
    assign tick     = run;
  end else begin : g_presc
    localparam int unsigned PW = clog2_min1(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_presc;

    assign tick = run && (r_presc == LAST);

    // Prescaler holds when not running; only LOAD (clr) or a tick resets it.
    always_ff @(posedge cnt_clk or negedge cnt_rst) begin
      if (!cnt_rst) begin
        r_presc <= '0;
      end else if (clr) begin
        r_presc <= '0;
      end else if (run) begin
        r_presc <= (r_presc == LAST) ? '0 : r_presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/up_down_cnt_param.sv
// Parametrised up/down counter with parallel load, enable + prescaler,
// terminal-count flags and a one-cycle wrap pulse.
// Optional feature macro: UP_DOWN_CNT_SAT_EN adds the sat_mode port
// (1 = saturate at the boundaries instead of wrapping).
// Ports:
//   cnt_clk     in   clock
//   cnt_rst     in   async active-low reset
//   cnt_in0/1   in   mode = {cnt_in1, cnt_in0}: hold/up/down/load
//   cnt_en      in   enable for counting (load ignores it)
//   load_val    in   parallel load value, clamped to MAX_VAL
//   sat_mode    in   saturate select (UP_DOWN_CNT_SAT_EN only)
//   count_out   out  current count
//   cnt_max     out  count == MAX_VAL
//   cnt_zero    out  count == 0
//   wrap_pulse  out  one cycle high when a wrapped value appears
module up_down_cnt_param
  import up_down_cnt_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
  parameter int unsigned RST_VAL  = 0,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             cnt_clk,
  input  logic             cnt_rst,
  input  logic             cnt_in0,
  input  logic             cnt_in1,
  input  logic             cnt_en,
  input  logic [WIDTH-1:0] load_val,
`ifdef UP_DOWN_CNT_SAT_EN
  input  logic             sat_mode,
`endif
  output logic [WIDTH-1:0] count_out,
  output logic             cnt_max,
  output logic             cnt_zero,
  output logic             wrap_pulse
);

  // Parameter legality
  if (WIDTH < 2) begin : g_chk_width
    $error("up_down_cnt_param: WIDTH must be >= 2");
  end
  if ((MAX_VAL < 1) || (64'(MAX_VAL) > ((64'(1) << WIDTH) - 64'(1)))) begin : g_chk_max
    $error("up_down_cnt_param: MAX_VAL out of range");
  end
  if (RST_VAL > MAX_VAL) begin : g_chk_rst
    $error("up_down_cnt_param: RST_VAL must be <= MAX_VAL");
  end
  if (PRESCALE < 1) begin : g_chk_presc
    $error("up_down_cnt_param: PRESCALE must be >= 1");
  end

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

  cnt_mode_e        w_mode;
  logic             w_run;
  logic             w_clr;
  logic             w_tick;
  logic             w_sat;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_wrap_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic             r_wrap;

  assign w_mode = cnt_mode_e'({cnt_in1, cnt_in0});
  assign w_run  = cnt_en && ((w_mode == CNT_UP) || (w_mode == CNT_DOWN));
  assign w_clr  = (w_mode == CNT_LOAD);

`ifdef UP_DOWN_CNT_SAT_EN
  assign w_sat = sat_mode;
`else
  assign w_sat = 1'b0;
`endif

  cnt_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .cnt_clk (cnt_clk),
    .cnt_rst (cnt_rst),
    .run     (w_run),
    .clr     (w_clr),
    .tick    (w_tick)
  );

  // Next count and wrap detection; saturation still consumes the tick.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_wrap_nxt = 1'b0;
    case (w_mode)
      CNT_LOAD: begin
        w_cnt_nxt = (load_val > MAX_W) ? MAX_W : load_val;
      end
      CNT_UP: begin
        if (w_tick) begin
          if (r_cnt != MAX_W) begin
            w_cnt_nxt = r_cnt + WIDTH'(1);
          end else if (!w_sat) begin
            w_cnt_nxt  = '0;
            w_wrap_nxt = 1'b1;
          end
        end
      end
      CNT_DOWN: begin
        if (w_tick) begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - WIDTH'(1);
          end else if (!w_sat) begin
            w_cnt_nxt  = MAX_W;
            w_wrap_nxt = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Count and wrap-pulse registers
  always_ff @(posedge cnt_clk or negedge cnt_rst) begin
    if (!cnt_rst) begin
      r_cnt  <= RST_W;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign count_out  = r_cnt;
  assign cnt_max    = (r_cnt == MAX_W);
  assign cnt_zero   = (r_cnt == '0);
  assign wrap_pulse = r_wrap;

endmodule

// File: tb/tb_up_down_cnt_param.sv
// Bench for up_down_cnt_param: four instances with different parameters
// share one stimulus stream; each is compared against an arithmetic model.
//   inst 0: defaults (MAX 15, RST 0, PRESCALE 1)
//   inst 1: MAX 9, RST 5
//   inst 2: MAX 12
//   inst 3: PRESCALE 4
module tb_up_down_cnt_param;

  localparam int NI = 4;
  localparam int MAXV [NI] = '{15, 9, 12, 15};
  localparam int RSTV [NI] = '{0, 5, 0, 0};
  localparam int PRES [NI] = '{1, 1, 1, 4};
`ifdef UP_DOWN_CNT_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic            cnt_clk = 1'b0;
  logic            cnt_rst;
  logic            cnt_in0;
  logic            cnt_in1;
  logic            cnt_en;
  logic [3:0]      load_val;
  logic            sat_mode;
  logic [NI-1:0][3:0] cnt_o;
  logic [NI-1:0]   max_o;
  logic [NI-1:0]   zero_o;
  logic [NI-1:0]   wrap_o;

  int m_cnt  [NI];
  int m_pre  [NI];
  int m_wrap [NI];
  int n_chk  = 0;
  int n_pass = 0;

  always #5 cnt_clk = ~cnt_clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    up_down_cnt_param #(
      .WIDTH    (4),
      .MAX_VAL  (MAXV[g]),
      .RST_VAL  (RSTV[g]),
      .PRESCALE (PRES[g])
    ) u_dut (
      .cnt_clk    (cnt_clk),
      .cnt_rst    (cnt_rst),
      .cnt_in0    (cnt_in0),
      .cnt_in1    (cnt_in1),
      .cnt_en     (cnt_en),
      .load_val   (load_val),
`ifdef UP_DOWN_CNT_SAT_EN
      .sat_mode   (sat_mode),
`endif
      .count_out  (cnt_o[g]),
      .cnt_max    (max_o[g]),
      .cnt_zero   (zero_o[g]),
      .wrap_pulse (wrap_o[g])
    );
  end

  // Reference behaviour for one rising edge, from the documented rules.
  task automatic model_edge();
    int  mode;
    bit  sat;
    mode = int'({cnt_in1, cnt_in0});
    sat  = SAT_EN && sat_mode;
    for (int i = 0; i < NI; i++) begin
      m_wrap[i] = 0;
      if (!cnt_rst) begin
        m_cnt[i] = RSTV[i];
        m_pre[i] = 0;
      end else if (mode == 3) begin
        m_cnt[i] = (int'(load_val) > MAXV[i]) ? MAXV[i] : int'(load_val);
        m_pre[i] = 0;
      end else if (cnt_en && (mode == 1 || mode == 2)) begin
        if (m_pre[i] < PRES[i] - 1) begin
          m_pre[i]++;
        end else begin
          m_pre[i] = 0;
          if (mode == 1) begin
            if (m_cnt[i] < MAXV[i]) m_cnt[i]++;
            else if (!sat) begin m_cnt[i] = 0; m_wrap[i] = 1; end
          end else begin
            if (m_cnt[i] > 0) m_cnt[i]--;
            else if (!sat) begin m_cnt[i] = MAXV[i]; m_wrap[i] = 1; end
          end
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = RSTV[i]; m_pre[i] = 0; m_wrap[i] = 0;
    end
  endtask

  // Apply inputs, take one edge, update the model, settle 1 time unit.
  task automatic step(input logic [1:0] mode, input logic en, input logic [3:0] lv);
    {cnt_in1, cnt_in0} = mode;
    cnt_en   = en;
    load_val = lv;
    @(posedge cnt_clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] obs, exp;
    cnt_rst = 1'b0; sat_mode = 1'b0;
    {cnt_in1, cnt_in0} = 2'b00; cnt_en = 1'b0; load_val = 4'd0;
    model_reset();
    #12;
    for (int i = 0; i < NI; i++) begin
      obs = {cnt_o[i], max_o[i], zero_o[i], wrap_o[i]};
      exp = {4'(m_cnt[i]), m_cnt[i] == MAXV[i], m_cnt[i] == 0, m_wrap[i] != 0};
      n_chk++;
      if (obs !== exp) $display("FAIL reset_init inst%0d got=%b want=%b", i, obs, exp);
      else n_pass++;
    end
    @(posedge cnt_clk); #1;
    cnt_rst = 1'b1;
    step(2'b11, 1'b0, 4'd0);
    for (int k = 0; k < 7; k++) step(2'b01, 1'b1, 4'd0);
    n_chk++;
    if (cnt_o[0] !== 4'd7) $display("FAIL reset_pre_count got=%0d want=7", cnt_o[0]);
    else n_pass++;
    // Asynchronous assertion between edges
    #2;
    cnt_rst = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      obs = {cnt_o[i], max_o[i], zero_o[i], wrap_o[i]};
      exp = {4'(m_cnt[i]), m_cnt[i] == MAXV[i], m_cnt[i] == 0, m_wrap[i] != 0};
      n_chk++;
      if (obs !== exp) $display("FAIL reset_async inst%0d got=%b want=%b", i, obs, exp);
      else n_pass++;
    end
    step(2'b01, 1'b1, 4'd0);
    cnt_rst = 1'b1;
  endtask

  task automatic test_up_wrap();
    logic [6:0] obs, exp;
    step(2'b11, 1'b0, 4'd14);
    for (int k = 0; k < 3; k++) begin
      step(2'b01, 1'b1, 4'd0);
      for (int i = 0; i < NI; i++) begin
        obs = {cnt_o[i], max_o[i], zero_o[i], wrap_o[i]};
        exp = {4'(m_cnt[i]), m_cnt[i] == MAXV[i], m_cnt[i] == 0, m_wrap[i] != 0};
        n_chk++;
        if (obs !== exp) $display("FAIL up_wrap step%0d inst%0d got=%b want=%b", k, i, obs, exp);
        else n_pass++;
      end
    end
    // Default instance ends 14 -> 15 -> 0 (pulse) -> 1 (no pulse)
    n_chk++;
    if ({cnt_o[0], wrap_o[0]} !== {4'd1, 1'b0})
      $display("FAIL up_wrap_final got=%0d/%b want=1/0", cnt_o[0], wrap_o[0]);
    else n_pass++;
  endtask

  task automatic test_down_wrap();
    logic [6:0] obs, exp;
    step(2'b11, 1'b0, 4'd1);
    for (int k = 0; k < 3; k++) begin
      step(2'b10, 1'b1, 4'd0);
      for (int i = 0; i < NI; i++) begin
        obs = {cnt_o[i], max_o[i], zero_o[i], wrap_o[i]};
        exp = {4'(m_cnt[i]), m_cnt[i] == MAXV[i], m_cnt[i] == 0, m_wrap[i] != 0};
        n_chk++;
        if (obs !== exp) $display("FAIL down_wrap step%0d inst%0d got=%b want=%b", k, i, obs, exp);
        else n_pass++;
      end
    end
    // MAX 9 instance: 1 -> 0 -> 9 (pulse) -> 8
    n_chk++;
    if (cnt_o[1] !== 4'd8) $display("FAIL down_wrap_final got=%0d want=8", cnt_o[1]);
    else n_pass++;
  endtask

  task automatic test_load();
    logic [6:0] obs, exp;
    step(2'b11, 1'b0, 4'd5);
    n_chk++;
    if (cnt_o[0] !== 4'd5) $display("FAIL load5 got=%0d want=5", cnt_o[0]);
    else n_pass++;
    step(2'b11, 1'b0, 4'd15);
    for (int i = 0; i < NI; i++) begin
      obs = {cnt_o[i], max_o[i], zero_o[i], wrap_o[i]};
      exp = {4'(m_cnt[i]), m_cnt[i] == MAXV[i], m_cnt[i] == 0, m_wrap[i] != 0};
      n_chk++;
      if (obs !== exp) $display("FAIL load_clamp inst%0d got=%b want=%b", i, obs, exp);
      else n_pass++;
    end
    n_chk++;
    if (cnt_o[2] !== 4'd12) $display("FAIL load_clamp12 got=%0d want=12", cnt_o[2]);
    else n_pass++;
  endtask

  task automatic test_prescale();
    logic [6:0] obs, exp;
    step(2'b11, 1'b0, 4'd0);
    for (int e = 1; e <= 12; e++) begin
      // Enable dropped for the two edges after the 5th
      step(2'b01, !(e == 6 || e == 7), 4'd0);
      obs = {cnt_o[3], max_o[3], zero_o[3], wrap_o[3]};
      exp = {4'(m_cnt[3]), m_cnt[3] == MAXV[3], m_cnt[3] == 0, m_wrap[3] != 0};
      n_chk++;
      if (obs !== exp) $display("FAIL prescale edge%0d got=%b want=%b", e, obs, exp);
      else n_pass++;
      if (e == 9 || e == 10) begin
        n_chk++;
        if (cnt_o[3] !== 4'((e == 10) ? 2 : 1))
          $display("FAIL prescale_shift edge%0d got=%0d", e, cnt_o[3]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_sat();
    logic [6:0] obs, exp;
    sat_mode = 1'b1;
    step(2'b11, 1'b0, 4'd15);
    for (int k = 0; k < 12; k++) begin
      step(2'b01, 1'b1, 4'd0);
      for (int i = 0; i < NI; i++) begin
        obs = {cnt_o[i], max_o[i], zero_o[i], wrap_o[i]};
        exp = {4'(m_cnt[i]), m_cnt[i] == MAXV[i], m_cnt[i] == 0, m_wrap[i] != 0};
        n_chk++;
        if (obs !== exp) $display("FAIL sat_up k%0d inst%0d got=%b want=%b", k, i, obs, exp);
        else n_pass++;
      end
    end
    step(2'b11, 1'b0, 4'd0);
    for (int k = 0; k < 4; k++) begin
      step(2'b10, 1'b1, 4'd0);
      for (int i = 0; i < NI; i++) begin
        obs = {cnt_o[i], max_o[i], zero_o[i], wrap_o[i]};
        exp = {4'(m_cnt[i]), m_cnt[i] == MAXV[i], m_cnt[i] == 0, m_wrap[i] != 0};
        n_chk++;
        if (obs !== exp) $display("FAIL sat_down k%0d inst%0d got=%b want=%b", k, i, obs, exp);
        else n_pass++;
      end
    end
    sat_mode = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0] obs, exp;
    int unsigned r;
    logic [1:0] mode;
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      mode = (r == 0) ? 2'b00 : (r <= 4) ? 2'b01 : (r <= 8) ? 2'b10 : 2'b11;
      sat_mode = 1'($urandom_range(0, 1));
      step(mode, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
      for (int i = 0; i < NI; i++) begin
        obs = {cnt_o[i], max_o[i], zero_o[i], wrap_o[i]};
        exp = {4'(m_cnt[i]), m_cnt[i] == MAXV[i], m_cnt[i] == 0, m_wrap[i] != 0};
        n_chk++;
        if (obs !== exp) $display("FAIL random k%0d inst%0d got=%b want=%b", k, i, obs, exp);
        else n_pass++;
      end
    end
    sat_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_prescale();
    test_sat();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
